// File: rtl/svi_lane_monitor_if.sv
// ============================================================================
// Module   : I
// Brief    : Per-lane scalar bundle (x, y, z); C is the consumer view.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface I;
    logic x;
    logic y;
    logic z;

    modport C (input x, input y, input z);
    modport D (output x, output y, output z);
endinterface

`default_nettype wire

// File: rtl/svi_lane_monitor.sv
// ============================================================================
// Module   : svi_lane_monitor
// Brief    : Samples an interface lane array, queues per-lane x/y/z change
//            events and serialises them round-robin onto a valid/ready stream.
//            Define SVI_MON_SYNC_EN to add a 2-flop synchroniser per input bit.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module svi_lane_monitor #(
    parameter int N_LANES = 8,
    parameter int LANE_W  = (N_LANES > 1) ? $clog2(N_LANES) : 1,
    parameter int CNT_W   = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    I.C                        c [N_LANES-1:0],
    input  logic               i_clr,
    input  logic               i_ready,
    output logic               o_valid,
    output logic [LANE_W-1:0]  o_lane,
    output logic [2:0]         o_xyz,
    output logic [N_LANES-1:0] o_overrun,
    output logic [CNT_W-1:0]   o_evt_cnt
);

    localparam logic [CNT_W-1:0]  c_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [LANE_W-1:0] c_LAST_IDX = LANE_W'(N_LANES - 1);

    logic [N_LANES-1:0][2:0] w_lane_in;
    logic [N_LANES-1:0][2:0] w_smp_src;
    logic [N_LANES-1:0][2:0] r_smp;
    logic [N_LANES-1:0][2:0] r_prev;
    logic [N_LANES-1:0][2:0] r_snap;
    logic [N_LANES-1:0]      r_pend;
    logic [LANE_W-1:0]       r_ptr;

    logic [N_LANES-1:0]      w_chg;
    logic [N_LANES-1:0]      w_take;
    logic [N_LANES-1:0]      w_ovr_set;
    logic                    w_found;
    logic                    w_load;
    logic                    w_xfer;
    logic [LANE_W-1:0]       w_winner;
    logic [LANE_W-1:0]       w_idx;
    int                      w_pos;

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        assign w_lane_in[g] = {c[g].x, c[g].y, c[g].z};
        assign w_chg[g]     = (r_smp[g] != r_prev[g]);
        assign w_take[g]    = w_load && (w_winner == LANE_W'(g));
    end

`ifdef SVI_MON_SYNC_EN
    logic [N_LANES-1:0][2:0] r_sync1;
    logic [N_LANES-1:0][2:0] r_sync2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_lane_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_smp_src = r_sync2;
`else
    assign w_smp_src = w_lane_in;
`endif

    // First pending lane at or after the pointer, wrapping modulo N_LANES.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_pos    = 0;
        w_idx    = '0;
        for (int k = 0; k < N_LANES; k++) begin
            w_pos = int'(r_ptr) + k;
            if (w_pos >= N_LANES) begin
                w_pos = w_pos - N_LANES;
            end
            w_idx = LANE_W'(w_pos);
            if (!w_found && r_pend[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_load    = (!o_valid || i_ready) && w_found;
    assign w_xfer    = o_valid && i_ready;
    // A fresh change on the lane being loaded re-arms pend without loss.
    assign w_ovr_set = w_chg & r_pend & ~w_take;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_smp  <= '0;
            r_prev <= '0;
            r_snap <= '0;
            r_pend <= '0;
        end else begin
            r_smp  <= w_smp_src;
            r_prev <= r_smp;
            for (int i = 0; i < N_LANES; i++) begin
                if (w_chg[i]) begin
                    r_snap[i] <= r_smp[i];
                    r_pend[i] <= 1'b1;
                end else if (w_take[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_lane  <= '0;
            o_xyz   <= '0;
            r_ptr   <= '0;
        end else if (w_load) begin
            o_valid <= 1'b1;
            o_lane  <= w_winner;
            o_xyz   <= r_snap[w_winner];
            r_ptr   <= (w_winner == c_LAST_IDX) ? '0 : w_winner + LANE_W'(1);
        end else if (!o_valid || i_ready) begin
            o_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_overrun <= '0;
            o_evt_cnt <= '0;
        end else begin
            if (i_clr) begin
                o_overrun <= '0;
            end else begin
                o_overrun <= o_overrun | w_ovr_set;
            end

            if (i_clr) begin
                o_evt_cnt <= '0;
            end else if (w_xfer && (o_evt_cnt != c_CNT_MAX)) begin
                o_evt_cnt <= o_evt_cnt + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire
